sram_access_ctrl: RTL and testbench

Memory-side stage directly downstream of the LC-3 control unit. It converts the control unit's active-low memory strobes (Mem_CE/Mem_OE/Mem_WE/Mem_UB/Mem_LB), plus MAR and MDR, into correctly sequenced SRAM pin timing with a programmable wait-state count. It returns registered read data to the MDR input mux and a one-cycle Mem_Ready pulse, so fetch and load/store states can wait on a handshake instead of fixed cycle counts.

---
 rtl/sram_access_ctrl.sv | 166 ++++++++++++++++
 tb/tb_sram_access_ctrl.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_access_ctrl.sv
// LC-3 memory strobes to sequenced SRAM pin timing; read ready WAIT_CYCLES+1, write WAIT_CYCLES+3 cycles after acceptance.
// A request held low yields one access; a new one needs Mem_OE and Mem_WE released first. All outputs are registered.
module sram_access_ctrl #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Mem_CE,
    input  logic              Mem_OE,
    input  logic              Mem_WE,
    input  logic              Mem_UB,
    input  logic              Mem_LB,
    input  logic [ADDR_W-1:0] ADDR,
    input  logic [DATA_W-1:0] Data_from_CPU,
    output logic [DATA_W-1:0] Data_to_CPU,
    output logic              Mem_Ready,
    output logic              SRAM_CE_N,
    output logic              SRAM_UB_N,
    output logic              SRAM_LB_N,
    output logic              SRAM_OE_N,
    output logic              SRAM_WE_N,
    output logic [ADDR_W-1:0] SRAM_ADDR,
    input  logic [DATA_W-1:0] SRAM_DQ_in,
    output logic [DATA_W-1:0] SRAM_DQ_out,
    output logic              SRAM_DQ_oe
);

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR_SETUP,
        WR,
        WR_HOLD,
        DONE,
        RELEASE
    } state_t;

    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdat_q, wdat_d;
    logic [DATA_W-1:0] rdat_q, rdat_d;
    logic              ub_q, ub_d;
    logic              lb_q, lb_d;
    logic              ce_n_q, ce_n_d;
    logic              oe_n_q, oe_n_d;
    logic              we_n_q, we_n_d;
    logic              ub_n_q, ub_n_d;
    logic              lb_n_q, lb_n_d;
    logic              dq_oe_q, dq_oe_d;
    logic              rdy_q, rdy_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdat_d  = wdat_q;
        rdat_d  = rdat_q;
        ub_d    = ub_q;
        lb_d    = lb_q;

        case (state_q)
            IDLE: begin
                if (!Mem_CE && (!Mem_WE || !Mem_OE)) begin
                    addr_d = ADDR;
                    wdat_d = Data_from_CPU;
                    ub_d   = Mem_UB;
                    lb_d   = Mem_LB;
                    // Write wins when both requests are low
                    if (!Mem_WE) begin
                        state_d = WR_SETUP;
                    end else begin
                        state_d = RD;
                        cnt_d   = CNT_LOAD;
                    end
                end
            end
            RD: begin
                if (cnt_q == 4'd0) begin
                    rdat_d  = SRAM_DQ_in;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_SETUP: begin
                cnt_d   = CNT_LOAD;
                state_d = WR;
            end
            WR: begin
                if (cnt_q == 4'd0) begin
                    state_d = WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WR_HOLD: state_d = DONE;
            DONE:    state_d = RELEASE;
            RELEASE: begin
                if (Mem_OE && Mem_WE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Pin values are decoded from the next state so they are registered with it
        ce_n_d  = !(state_d == RD || state_d == WR_SETUP || state_d == WR || state_d == WR_HOLD);
        oe_n_d  = (state_d != RD);
        we_n_d  = (state_d != WR);
        ub_n_d  = ce_n_d | ub_d;
        lb_n_d  = ce_n_d | lb_d;
        dq_oe_d = (state_d == WR_SETUP || state_d == WR || state_d == WR_HOLD);
        rdy_d   = (state_d == DONE);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdat_q  <= '0;
            rdat_q  <= '0;
            ub_q    <= 1'b1;
            lb_q    <= 1'b1;
            ce_n_q  <= 1'b1;
            oe_n_q  <= 1'b1;
            we_n_q  <= 1'b1;
            ub_n_q  <= 1'b1;
            lb_n_q  <= 1'b1;
            dq_oe_q <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdat_q  <= wdat_d;
            rdat_q  <= rdat_d;
            ub_q    <= ub_d;
            lb_q    <= lb_d;
            ce_n_q  <= ce_n_d;
            oe_n_q  <= oe_n_d;
            we_n_q  <= we_n_d;
            ub_n_q  <= ub_n_d;
            lb_n_q  <= lb_n_d;
            dq_oe_q <= dq_oe_d;
            rdy_q   <= rdy_d;
        end
    end

    assign Data_to_CPU = rdat_q;
    assign Mem_Ready   = rdy_q;
    assign SRAM_CE_N   = ce_n_q;
    assign SRAM_UB_N   = ub_n_q;
    assign SRAM_LB_N   = lb_n_q;
    assign SRAM_OE_N   = oe_n_q;
    assign SRAM_WE_N   = we_n_q;
    assign SRAM_ADDR   = addr_q;
    assign SRAM_DQ_out = wdat_q;
    assign SRAM_DQ_oe  = dq_oe_q;

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Bench for sram_access_ctrl: instance 0 (WAIT_CYCLES=2) talks to a small SRAM model,
// instances 1 and 2 (WAIT_CYCLES=1 and 15) read a fixed data pattern.
module tb_sram_access_ctrl;

    logic        Clk = 1'b0;
    logic [2:0]  rst, ce, oe, we;
    logic        ub, lb;
    logic [19:0] addr;
    logic [15:0] wd;
    logic [2:0]  ce_n, oe_n, we_n, ub_n, lb_n, dq_oe, rdy;
    logic [15:0] rd    [3];
    logic [19:0] saddr [3];
    logic [15:0] dqo   [3];
    logic [15:0] model_dq;
    logic [15:0] mem   [256];
    logic        mem_load;
    int          n_vec  = 0;
    int          n_fail = 0;

    always #5 Clk = ~Clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        sram_access_ctrl #(
            .ADDR_W      (20),
            .DATA_W      (16),
            .WAIT_CYCLES (g == 0 ? 2 : (g == 1 ? 1 : 15))
        ) u_dut (
            .Clk           (Clk),
            .Reset         (rst[g]),
            .Mem_CE        (ce[g]),
            .Mem_OE        (oe[g]),
            .Mem_WE        (we[g]),
            .Mem_UB        (ub),
            .Mem_LB        (lb),
            .ADDR          (addr),
            .Data_from_CPU (wd),
            .Data_to_CPU   (rd[g]),
            .Mem_Ready     (rdy[g]),
            .SRAM_CE_N     (ce_n[g]),
            .SRAM_UB_N     (ub_n[g]),
            .SRAM_LB_N     (lb_n[g]),
            .SRAM_OE_N     (oe_n[g]),
            .SRAM_WE_N     (we_n[g]),
            .SRAM_ADDR     (saddr[g]),
            .SRAM_DQ_in    (g == 0 ? model_dq : 16'hA5C3),
            .SRAM_DQ_out   (dqo[g]),
            .SRAM_DQ_oe    (dq_oe[g])
        );
    end

    always_comb model_dq = (!ce_n[0] && !oe_n[0]) ? mem[saddr[0][7:0]] : 16'hDEAD;

    always @(posedge Clk) begin
        if (mem_load) begin
            for (int i = 0; i < 256; i++) mem[i] <= 16'h0000;
            mem[8'h10] <= 16'h1234;
            mem[8'h30] <= 16'h3030;
            mem[8'h31] <= 16'h3131;
            mem[8'h40] <= 16'hAB00;
        end else if (!ce_n[0] && !we_n[0] && dq_oe[0]) begin
            if (!lb_n[0]) mem[saddr[0][7:0]][7:0]  <= dqo[0][7:0];
            if (!ub_n[0]) mem[saddr[0][7:0]][15:8] <= dqo[0][15:8];
        end
    end

    typedef struct {
        logic        rst, ce, oe, we, ub, lb;
        logic [19:0] addr;
        logic [15:0] wd;
        logic [4:0]  strb;   // {CE_N, OE_N, WE_N, UB_N, LB_N}
        logic        dq_oe, rdy;
        logic [15:0] rd;
        logic [19:0] saddr;
        logic [15:0] dqo;
    } vec_t;

    vec_t tbl [30];

    function automatic vec_t mk(input int r, input int c, input int o, input int w, input int u,
                                input int l, input int a, input int d, input int s, input int qoe,
                                input int rr, input int erd, input int esa, input int edq);
        vec_t v;
        v.rst = r[0]; v.ce = c[0]; v.oe = o[0]; v.we = w[0]; v.ub = u[0]; v.lb = l[0];
        v.addr = a[19:0]; v.wd = d[15:0]; v.strb = s[4:0]; v.dq_oe = qoe[0]; v.rdy = rr[0];
        v.rd = erd[15:0]; v.saddr = esa[19:0]; v.dqo = edq[15:0];
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    task automatic read_lat(input int k, input int w, input logic [19:0] a, input logic [15:0] exp_rd);
        int   n, lows;
        logic got;
        n = 0; lows = 0; got = 1'b0;
        addr = a; ce[k] = 1'b0; oe[k] = 1'b0;
        @(posedge Clk);
        while (!got && n < 40) begin
            @(negedge Clk);
            n++;
            if (!oe_n[k]) lows++;
            if (rdy[k]) got = 1'b1;
        end
        chk($sformatf("lat_k%0d", k), 64'(n), 64'(w + 1));
        chk($sformatf("oe_lows_k%0d", k), 64'(lows), 64'(w));
        chk($sformatf("rdata_k%0d", k), 64'(rd[k]), 64'(exp_rd));
        ce[k] = 1'b1; oe[k] = 1'b1;
        repeat (3) @(negedge Clk);
    endtask

    task automatic reset_abort(input int k);
        int lows, pulses;
        addr = 20'h00010; ce[k] = 1'b0; oe[k] = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        chk($sformatf("rd1_strobes_k%0d", k), 64'({ce_n[k], oe_n[k]}), 64'(0));
        rst[k] = 1'b1; ce[k] = 1'b1; oe[k] = 1'b1;
        @(posedge Clk);
        @(negedge Clk);
        chk($sformatf("rst_strobes_k%0d", k),
            64'({ce_n[k], oe_n[k], we_n[k], ub_n[k], lb_n[k], dq_oe[k]}), 64'(6'b111110));
        chk($sformatf("rst_rdata_k%0d", k), 64'(rd[k]), 64'(0));
        chk($sformatf("rst_ready_k%0d", k), 64'(rdy[k]), 64'(0));
        chk($sformatf("rst_addr_k%0d", k), 64'(saddr[k]), 64'(0));
        rst[k] = 1'b0;
        lows = 0; pulses = 0;
        repeat (4) begin
            @(negedge Clk);
            if (!oe_n[k]) lows++;
            if (rdy[k]) pulses++;
        end
        chk($sformatf("post_rst_quiet_k%0d", k), 64'(lows + pulses), 64'(0));
    endtask

    initial begin
        int   lows, pulses, n;
        logic got;
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int   lows, pulses, n;
        logic got;

        rst = 3'b111; ce = 3'b111; oe = 3'b111; we = 3'b111;
        ub = 1'b0; lb = 1'b0; addr = 20'h0; wd = 16'h0; mem_load = 1'b1;
        repeat (2) @(negedge Clk);
        mem_load = 1'b0;
        rst[2:1] = 2'b00;

        //            rst ce oe we ub lb addr   wd       strb     oe rdy rd       saddr  dqo
        tbl[0]  = mk(1, 1, 1, 1, 0, 0, 'h00, 'h0000, 'b11111, 0, 0, 'h0000, 'h00, 'h0000);
        tbl[1]  = mk(0, 1, 1, 1, 0, 0, 'h00, 'h0000, 'b11111, 0, 0, 'h0000, 'h00, 'h0000);
        tbl[2]  = mk(0, 0, 0, 1, 0, 0, 'h10, 'h5555, 'b00100, 0, 0, 'h0000, 'h10, 'h5555);
        tbl[3]  = mk(0, 0, 0, 1, 0, 0, 'h10, 'h5555, 'b00100, 0, 0, 'h0000, 'h10, 'h5555);
        tbl[4]  = mk(0, 0, 0, 1, 0, 0, 'h10, 'h5555, 'b11111, 0, 1, 'h1234, 'h10, 'h5555);
        tbl[5]  = mk(0, 0, 0, 1, 0, 0, 'h10, 'h5555, 'b11111, 0, 0, 'h1234, 'h10, 'h5555);
        tbl[6]  = mk(0, 0, 0, 1, 0, 0, 'h10, 'h5555, 'b11111, 0, 0, 'h1234, 'h10, 'h5555);
        tbl[7]  = mk(0, 1, 1, 1, 0, 0, 'h10, 'h5555, 'b11111, 0, 0, 'h1234, 'h10, 'h5555);
        tbl[8]  = mk(0, 0, 1, 0, 0, 0, 'h20, 'hBEEF, 'b01100, 1, 0, 'h1234, 'h20, 'hBEEF);
        tbl[9]  = mk(0, 0, 1, 0, 0, 0, 'h20, 'hBEEF, 'b01000, 1, 0, 'h1234, 'h20, 'hBEEF);
        tbl[10] = mk(0, 0, 1, 0, 0, 0, 'h21, 'h0000, 'b01000, 1, 0, 'h1234, 'h20, 'hBEEF);
        tbl[11] = mk(0, 0, 1, 0, 0, 0, 'h21, 'h0000, 'b01100, 1, 0, 'h1234, 'h20, 'hBEEF);
        tbl[12] = mk(0, 0, 1, 0, 0, 0, 'h21, 'h0000, 'b11111, 0, 1, 'h1234, 'h20, 'hBEEF);
        tbl[13] = mk(0, 1, 1, 1, 0, 0, 'h21, 'h0000, 'b11111, 0, 0, 'h1234, 'h20, 'hBEEF);
        tbl[14] = mk(0, 1, 1, 1, 0, 0, 'h21, 'h0000, 'b11111, 0, 0, 'h1234, 'h20, 'hBEEF);
        tbl[15] = mk(0, 0, 0, 1, 0, 0, 'h20, 'h0000, 'b00100, 0, 0, 'h1234, 'h20, 'h0000);
        tbl[16] = mk(0, 0, 0, 1, 0, 0, 'h20, 'h0000, 'b00100, 0, 0, 'h1234, 'h20, 'h0000);
        tbl[17] = mk(0, 0, 0, 1, 0, 0, 'h20, 'h0000, 'b11111, 0, 1, 'hBEEF, 'h20, 'h0000);
        tbl[18] = mk(0, 1, 1, 1, 0, 0, 'h20, 'h0000, 'b11111, 0, 0, 'hBEEF, 'h20, 'h0000);
        tbl[19] = mk(0, 1, 1, 1, 0, 0, 'h20, 'h0000, 'b11111, 0, 0, 'hBEEF, 'h20, 'h0000);
        tbl[20] = mk(0, 0, 0, 0, 1, 0, 'h40, 'h00FF, 'b01110, 1, 0, 'hBEEF, 'h40, 'h00FF);
        tbl[21] = mk(0, 0, 0, 0, 1, 0, 'h40, 'h00FF, 'b01010, 1, 0, 'hBEEF, 'h40, 'h00FF);
        tbl[22] = mk(0, 0, 0, 0, 1, 0, 'h40, 'h00FF, 'b01010, 1, 0, 'hBEEF, 'h40, 'h00FF);
        tbl[23] = mk(0, 0, 0, 0, 1, 0, 'h40, 'h00FF, 'b01110, 1, 0, 'hBEEF, 'h40, 'h00FF);
        tbl[24] = mk(0, 0, 0, 0, 1, 0, 'h40, 'h00FF, 'b11111, 0, 1, 'hBEEF, 'h40, 'h00FF);
        tbl[25] = mk(0, 0, 0, 0, 1, 0, 'h40, 'h00FF, 'b11111, 0, 0, 'hBEEF, 'h40, 'h00FF);
        tbl[26] = mk(0, 1, 1, 1, 0, 0, 'h40, 'h00FF, 'b11111, 0, 0, 'hBEEF, 'h40, 'h00FF);
        tbl[27] = mk(0, 1, 0, 1, 0, 0, 'h50, 'h1111, 'b11111, 0, 0, 'hBEEF, 'h40, 'h00FF);
        tbl[28] = mk(0, 1, 0, 1, 0, 0, 'h50, 'h1111, 'b11111, 0, 0, 'hBEEF, 'h40, 'h00FF);
        tbl[29] = mk(0, 1, 1, 1, 0, 0, 'h50, 'h1111, 'b11111, 0, 0, 'hBEEF, 'h40, 'h00FF);

        for (int i = 0; i < 30; i++) begin
            rst[0] = tbl[i].rst; ce[0] = tbl[i].ce; oe[0] = tbl[i].oe; we[0] = tbl[i].we;
            ub = tbl[i].ub; lb = tbl[i].lb; addr = tbl[i].addr; wd = tbl[i].wd;
            @(posedge Clk);
            @(negedge Clk);
            chk($sformatf("row%0d", i),
                {5'b0, ce_n[0], oe_n[0], we_n[0], ub_n[0], lb_n[0], dq_oe[0], rdy[0], rd[0], saddr[0], dqo[0]},
                {5'b0, tbl[i].strb, tbl[i].dq_oe, tbl[i].rdy, tbl[i].rd, tbl[i].saddr, tbl[i].dqo});
        end

        // Read held low through DONE and 10 more cycles: one access only
        addr = 20'h00040; ce[0] = 1'b0; oe[0] = 1'b0;
        @(posedge Clk);
        lows = 0; pulses = 0;
        repeat (13) begin
            @(negedge Clk);
            if (!oe_n[0]) lows++;
            if (rdy[0]) pulses++;
        end
        chk("hold_ready_pulses", 64'(pulses), 64'(1));
        chk("hold_oe_lows", 64'(lows), 64'(2));
        chk("hold_rdata_byte_write", 64'(rd[0]), 64'(16'hABFF));
        ce[0] = 1'b1; oe[0] = 1'b1;
        repeat (2) @(negedge Clk);
        addr = 20'h00010; ce[0] = 1'b0; oe[0] = 1'b0;
        @(posedge Clk);
        got = 1'b0; n = 0;
        while (!got && n < 20) begin
            @(negedge Clk);
            n++;
            if (rdy[0]) got = 1'b1;
        end
        chk("reassert_ready", 64'(got), 64'(1));
        chk("reassert_rdata", 64'(rd[0]), 64'(16'h1234));
        ce[0] = 1'b1; oe[0] = 1'b1;
        repeat (3) @(negedge Clk);

        // ADDR change during RD is ignored
        addr = 20'h00030; ce[0] = 1'b0; oe[0] = 1'b0;
        @(posedge Clk);
        @(negedge Clk);
        chk("addr_rd1", 64'(saddr[0]), 64'(20'h00030));
        addr = 20'h00031;
        @(negedge Clk);
        chk("addr_rd2", 64'(saddr[0]), 64'(20'h00030));
        @(negedge Clk);
        chk("addr_ready", 64'(rdy[0]), 64'(1));
        chk("addr_rdata", 64'(rd[0]), 64'(16'h3030));
        ce[0] = 1'b1; oe[0] = 1'b1;
        repeat (3) @(negedge Clk);

        reset_abort(0);
        read_lat(0, 2, 20'h00010, 16'h1234);
        read_lat(1, 1, 20'h00010, 16'hA5C3);
        reset_abort(1);
        read_lat(1, 1, 20'h00010, 16'hA5C3);
        read_lat(2, 15, 20'h00010, 16'hA5C3);
        reset_abort(2);
        read_lat(2, 15, 20'h00010, 16'hA5C3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
